// File: rtl/dsp_out_stage.sv
// Output stage of the FIR datapath: round/scale the accumulator, optionally saturate,
// and buffer results in a first-word-fall-through FIFO. Define DSP_OUT_SAT_EN for saturation.
module dsp_out_stage #(
    parameter int N     = 16,
    parameter int N_IN  = 30,
    parameter int SHIFT = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic [N_IN-1:0]          in,
    input  logic                     clr,
    output logic [N-1:0]             out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     sat_flag,
    output logic [7:0]               drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int RW = N_IN + 1;
    localparam logic [PW:0] FULL_LVL = DEPTH[PW:0];

    function automatic logic [RW-1:0] round_shift(input logic [N_IN-1:0] x);
        logic [RW-1:0] sum;
        sum = {1'b0, x} + (RW'(1) << (SHIFT - 1));
        return sum >> SHIFT;
    endfunction

`ifdef DSP_OUT_SAT_EN
    function automatic logic is_ovf(input logic [RW-1:0] r);
        return (r >> N) != '0;
    endfunction

    function automatic logic [N-1:0] saturate(input logic [RW-1:0] r);
        return is_ovf(r) ? '1 : r[N-1:0];
    endfunction
`endif

    logic [N-1:0] data_p0;
    logic [N-1:0] stage_p1;
    logic         vld_p1;

`ifdef DSP_OUT_SAT_EN
    logic [RW-1:0] r_p0;
    logic          ovf_p0;

    assign r_p0    = round_shift(in);
    assign ovf_p0  = is_ovf(r_p0);
    assign data_p0 = saturate(r_p0);

    // Sticky clip flag; a clip in the same cycle as clr takes priority.
    always_ff @(posedge clk) begin
        if (rst)                 sat_flag <= 1'b0;
        else if (ena && ovf_p0)  sat_flag <= 1'b1;
        else if (clr)            sat_flag <= 1'b0;
    end
`else
    assign data_p0  = N'(round_shift(in));
    assign sat_flag = 1'b0;
`endif

    // ---- stage p0 -> p1: scaled sample register ----
    always_ff @(posedge clk) begin
        if (ena) stage_p1 <= data_p0;
    end

    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= ena;
    end

    // ---- stage p1 -> FIFO ----
    logic [N-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop;
    logic          push_ok;
    logic          drop;

    assign out_valid = (level != '0);
    assign pop       = out_valid && out_ready;
    assign push_ok   = vld_p1 && ((level != FULL_LVL) || pop);
    assign drop      = vld_p1 && !push_ok;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= stage_p1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Drop counter saturates at 255; a drop coinciding with clr leaves it at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= 8'd0;
        end else if (drop) begin
            if (clr)                    drop_cnt <= 8'd1;
            else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end else if (clr) begin
            drop_cnt <= 8'd0;
        end
    end

endmodule

// File: tb/tb_dsp_out_stage.sv
// Directed, table-driven bench for dsp_out_stage (default parameters).
module tb_dsp_out_stage;

    localparam int N     = 16;
    localparam int N_IN  = 30;
    localparam int SHIFT = 12;
    localparam int DEPTH = 4;

`ifdef DSP_OUT_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   ena;
    logic [N_IN-1:0]        in;
    logic                   clr;
    logic [N-1:0]           out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [$clog2(DEPTH):0] level;
    logic                   sat_flag;
    logic [7:0]             drop_cnt;

    always #5 clk = ~clk;

    dsp_out_stage #(.N(N), .N_IN(N_IN), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .ena(ena), .in(in), .clr(clr),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .sat_flag(sat_flag), .drop_cnt(drop_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [N_IN-1:0] din;
        logic [N-1:0]    exp_data;
        logic            exp_sat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{30'd6144,      16'd2,     1'b0};
        vecs[1] = '{30'd6143,      16'd1,     1'b0};
        vecs[2] = '{30'd0,         16'd0,     1'b0};
        vecs[3] = '{30'd2047,      16'd0,     1'b0};
        vecs[4] = '{30'd2048,      16'd1,     1'b0};
        vecs[5] = '{30'd409600,    16'd100,   1'b0};
        vecs[6] = '{30'd268433407, 16'd65535, 1'b0};
        vecs[7] = '{30'd268433408, SAT_EN ? 16'hFFFF : 16'h0000, SAT_EN};
        vecs[8] = '{30'h3FFF_FFFF, SAT_EN ? 16'hFFFF : 16'h0000, SAT_EN};

        rst = 1'b1; ena = 1'b0; in = '0; clr = 1'b0; out_ready = 1'b0;
        step();
        step();
        check("rst_level", level, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_sat", sat_flag, 0);
        check("rst_drop", drop_cnt, 0);
        rst = 1'b0;
        step();

        // Single samples: latency, one-cycle valid, rounding and overflow handling.
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            in = vecs[i].din; ena = 1'b1;
            step();
            ena = 1'b0;
            check($sformatf("vec%0d_valid_t1", i), out_valid, 0);
            step();
            check($sformatf("vec%0d_valid_t2", i), out_valid, 1);
            check($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
            check($sformatf("vec%0d_sat", i), sat_flag, vecs[i].exp_sat);
            step();
            check($sformatf("vec%0d_valid_t3", i), out_valid, 0);
            clr = 1'b1;
            step();
            clr = 1'b0;
            check($sformatf("vec%0d_sat_clr", i), sat_flag, 0);
        end

        // Back-pressure: six samples into a four-deep FIFO.
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            in = 30'(k * 4096); ena = 1'b1;
            step();
        end
        ena = 1'b0;
        step();
        check("bp_level", level, 4);
        check("bp_drop", drop_cnt, 2);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("bp_valid%0d", k), out_valid, 1);
            check($sformatf("bp_data%0d", k), out_data, k);
            step();
        end
        check("bp_empty", out_valid, 0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("bp_drop_clr", drop_cnt, 0);

        // Full FIFO with simultaneous push and pop every cycle.
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            in = 30'(k * 4096); ena = 1'b1;
            step();
        end
        check("fp_level_full", level, 4);
        for (int j = 0; j < 10; j++) begin
            in = 30'((6 + j) * 4096); ena = 1'b1; out_ready = 1'b1;
            check($sformatf("fp_level%0d", j), level, 4);
            check($sformatf("fp_data%0d", j), out_data, j + 1);
            step();
        end
        ena = 1'b0;
        check("fp_level_end", level, 4);
        check("fp_drop", drop_cnt, 0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("fp_drain%0d", i), out_data, 11 + i);
            step();
        end
        check("fp_drained", out_valid, 0);

        // Reset with three queued entries and one staged.
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            in = 30'(k * 4096); ena = 1'b1;
            step();
        end
        check("mr_level_pre", level, 3);
        rst = 1'b1; in = 30'(9 * 4096); ena = 1'b1;
        step();
        rst = 1'b0; ena = 1'b0;
        check("mr_level", level, 0);
        check("mr_valid", out_valid, 0);
        check("mr_data", out_data, 0);
        step();
        check("mr_no_ghost", out_valid, 0);
        in = 30'(7 * 4096); ena = 1'b1;
        step();
        ena = 1'b0;
        check("mr_valid_t1", out_valid, 0);
        step();
        check("mr_valid_t2", out_valid, 1);
        check("mr_data_t2", out_data, 7);

        // Drop counter saturation.
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b0; in = 30'd4096; ena = 1'b1;
        repeat (300) step();
        ena = 1'b0;
        step();
        check("ds_drop", drop_cnt, 255);
        check("ds_level", level, 4);

        // A drop coinciding with clr leaves the count at 1.
        ena = 1'b1;
        step();
        ena = 1'b0; clr = 1'b1;
        step();
        check("dc_drop_wins", drop_cnt, 1);
        step();
        clr = 1'b0;
        check("dc_drop_clr", drop_cnt, 0);

        // An overflow coinciding with clr leaves sat_flag set (when saturation is built).
        in = 30'h3FFF_FFFF; ena = 1'b1; clr = 1'b1;
        step();
        ena = 1'b0;
        check("sc_sat_wins", sat_flag, SAT_EN);
        step();
        clr = 1'b0;
        check("sc_sat_clr", sat_flag, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dsp_out_stage.md
# dsp_out_stage

Output stage for the FIR datapath in `dsp`. Captures the filter's wide accumulator result on each `ena` sample strobe, rounds and scales it back to N bits, and saturates it. The result is buffered in a small FIFO and presented downstream on a valid/ready stream. The filter writes one result per `ena`; this block is the reader that absorbs those results and decouples the filter from a back-pressuring consumer.

## Interface
Parameters:
- `N`, 16: output sample width.
- `N_IN`, 30: accumulator input width; equals N + N_MULT + $clog2(N_TAPS) of the filter.
- `SHIFT`, 12: right-shift applied after rounding; must satisfy 1 ≤ SHIFT < N_IN.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.

Ports:
- `clk`, in, 1: single clock; all logic on rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `ena`, in, 1: sample strobe; `in` is valid when high.
- `in`, in, N_IN: unsigned filter accumulator result.
- `clr`, in, 1: clears `sat_flag` and `drop_cnt`.
- `out_data`, out, N: head-of-FIFO sample.
- `out_valid`, out, 1: `out_data` holds a sample.
- `out_ready`, in, 1: consumer accepts the sample.
- `level`, out, $clog2(DEPTH)+1: FIFO occupancy.
- `sat_flag`, out, 1: sticky; a sample was clipped.
- `drop_cnt`, out, 8: saturating count of samples dropped on full.

## Operation
- Stage 1 (scale) runs when `ena` is high at an edge:
  - Form `r = (in + 2^(SHIFT-1)) >> SHIFT` in N_IN+1 bits (round half up).
  - Load `r` into the stage register and set `stage_v`.
  - When `ena` is low, clear `stage_v`.
- Saturation: if any bit of `r` above bit N-1 is set, the staged value is 2^N−1 and `sat_flag` sets. Otherwise the staged value is `r[N-1:0]`.
- Stage 2 (FIFO write) occurs when `stage_v` is high:
  - Push is accepted if `level < DEPTH`, or if a pop happens in the same cycle.
  - If the push is not accepted, the sample is dropped and `drop_cnt` increments, holding at 255.
- Pop: a pop occurs when `out_valid && out_ready`.
- Output is first-word fall-through:
  - `out_valid = (level != 0)`.
  - `out_data` shows the oldest entry.
  - `out_data` stays stable while `out_valid && !out_ready`.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `level` tracks pushes minus pops.
- Simultaneous push and pop:
  - At `level == DEPTH`: both are accepted and `level` is unchanged.
  - At `level == 0`: only the push takes effect (pop is impossible because `out_valid` is 0).
- `clr` zeroes `sat_flag` and `drop_cnt` at the edge. A saturation or drop in that same cycle wins: `sat_flag` reads 1 and `drop_cnt` reads 1 after the edge.
- Reset:
  - Clears `stage_v`, the pointers, `level`, `out_data` (0), `out_valid` (0), `sat_flag` (0) and `drop_cnt` (0).
  - `ena` during `rst` is ignored.
  - Samples in flight at reset are discarded.

## Timing
- `ena` high in cycle t → stage register valid in cycle t+1 → FIFO write at the end of t+1 → `out_valid` high in cycle t+2 when the FIFO was empty. Latency is 2 cycles.
- Throughput is one sample per cycle; `ena` may be high every cycle.
- A pop in cycle t exposes the next entry in cycle t+1.
- `level`, `out_valid`, `sat_flag` and `drop_cnt` are all registered. There are no combinational paths from `ena` or `in` to any output.
- `out_ready` → `out_valid` has no combinational path; `out_valid` depends only on `level`.

## Configuration
- Macro: `DSP_OUT_SAT_EN`.
- Defined: saturation as described above.
- Undefined:
  - The staged value is `r[N-1:0]` (wrap-around).
  - `sat_flag` is tied to 0.
  - The overflow detect logic is not built.

## Test plan
Defaults: N=16, N_IN=30, SHIFT=12, DEPTH=4.
- Rounding: `in`=6144 with `ena` for 1 cycle, `out_ready`=1 → `out_data`=2, `out_valid` high exactly in cycle t+2 for 1 cycle. Then `in`=6143 → 1.
- Saturation: `in`=0x3FFF_FFFF.
  - With `DSP_OUT_SAT_EN` → `out_data`=0xFFFF, `sat_flag`=1.
  - Without → `out_data`=0x0000, `sat_flag`=0.
  - Then pulse `clr` → `sat_flag`=0.
- Back-pressure: `out_ready`=0, 6 consecutive `ena` with `in`=k·4096 for k=1..6 → `level`=4, `drop_cnt`=2. Raise `out_ready` → outputs 1, 2, 3, 4 in order, then `out_valid`=0.
- Full with simultaneous pop: fill 4 entries, then hold `ena` and `out_ready` high for 10 cycles → `level` stays 4, `drop_cnt` unchanged, output sequence continuous with no gaps.
- Reset mid-stream: 3 entries queued plus one staged, assert `rst` 1 cycle with `ena`=1 → next cycle `level`=0, `out_valid`=0, `out_data`=0. The first `ena` after reset yields `out_valid` 2 cycles later.
- Drop counter saturation: `out_ready`=0, 300 `ena` pulses → `drop_cnt`=255 (held), `level`=4.
